// File: rtl/mips_pipe_hazard.sv
// mips_pipe_hazard: 5-stage MIPS integer pipeline with forwarding,
// interlocks, branch flush, program/debug ports and perf counters.
module mips_pipe_hazard #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW = 10,
  parameter int FWD_EN = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic [31:0]      prog_data,
  input  logic [4:0]       dbg_raddr,
  output logic [31:0]      dbg_rdata,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [2:0] {
    T_NOP, T_RR, T_RM, T_LD, T_ST, T_BR, T_HLT
  } itype_t;

  localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02, OP_OR = 6'h03;
  localparam logic [5:0] OP_SLT = 6'h04, OP_MUL = 6'h05;
  localparam logic [5:0] OP_LW = 6'h08, OP_SW = 6'h09;
  localparam logic [5:0] OP_ADDI = 6'h0a, OP_SUBI = 6'h0b;
  localparam logic [5:0] OP_SLTI = 6'h0c, OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ = 6'h0e;

  typedef struct packed {
    logic          v;
    logic [31:0]   ir;
    logic [AW-1:0] npc;
  } if_id_t;

  typedef struct packed {
    logic          v;
    itype_t        t;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          we;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [31:0]   imm;
    logic [AW-1:0] npc;
  } id_ex_t;

  typedef struct packed {
    logic        v;
    itype_t      t;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] b;
  } ex_mem_t;

  typedef struct packed {
    logic        v;
    itype_t      t;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] res;
  } mem_wb_t;

  function automatic itype_t dec(input logic [5:0] op);
    itype_t t;
    unique case (1'b1)
      (op <= OP_MUL): t = T_RR;
      (op == OP_LW): t = T_LD;
      (op == OP_SW): t = T_ST;
      (op >= OP_ADDI && op <= OP_SLTI): t = T_RM;
      (op == OP_BNEQZ || op == OP_BEQZ): t = T_BR;
      default: t = T_HLT;
    endcase
    return t;
  endfunction

  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   rf [32];
  logic [AW-1:0] pc;
  logic          stop;
  if_id_t        if_id;
  id_ex_t        id_ex;
  ex_mem_t       ex_mem;
  mem_wb_t       mem_wb;

  logic wb_wr;
  assign wb_wr = mem_wb.we;
  assign dbg_rdata = rf[dbg_raddr];

  itype_t      d_t;
  logic [4:0]  d_rs, d_rt, d_rd, d_dst;
  logic        d_use_rt, d_we;
  logic [31:0] d_a, d_b, d_imm;
  assign d_t = if_id.v ? dec(if_id.ir[31:26]) : T_NOP;
  assign d_rs = if_id.ir[25:21];
  assign d_rt = if_id.ir[20:16];
  assign d_rd = if_id.ir[15:11];
  assign d_imm = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
  assign d_use_rt = (d_t == T_RR) || (d_t == T_ST);
  assign d_dst = (d_t == T_RR) ? d_rd : d_rt;
  assign d_we = (d_t == T_RR || d_t == T_RM || d_t == T_LD)
              && (d_dst != 5'd0);
  // WB-to-ID bypass: a same-cycle write is visible to the read
  assign d_a = (wb_wr && mem_wb.rd == d_rs) ? mem_wb.res : rf[d_rs];
  assign d_b = (wb_wr && mem_wb.rd == d_rt) ? mem_wb.res : rf[d_rt];

  logic hit_ex, hit_mem, stall;
  assign hit_ex = id_ex.we && (id_ex.rd == d_rs
                || (d_use_rt && id_ex.rd == d_rt));
  assign hit_mem = ex_mem.we && (ex_mem.rd == d_rs
                 || (d_use_rt && ex_mem.rd == d_rt));
  assign stall = (d_t != T_NOP) && ((FWD_EN != 0)
               ? (hit_ex && id_ex.t == T_LD)
               : (hit_ex || hit_mem));

  logic        em_fw;
  logic [31:0] fa, fb, alu;
  assign em_fw = ex_mem.we && ex_mem.t != T_LD;

  always_comb begin
    fa = id_ex.a;
    fb = id_ex.b;
    if (FWD_EN != 0) begin
      if (em_fw && ex_mem.rd == id_ex.rs) fa = ex_mem.alu;
      else if (wb_wr && mem_wb.rd == id_ex.rs) fa = mem_wb.res;
      if (em_fw && ex_mem.rd == id_ex.rt) fb = ex_mem.alu;
      else if (wb_wr && mem_wb.rd == id_ex.rt) fb = mem_wb.res;
    end
  end

  always_comb begin
    alu = fa + id_ex.imm;
    unique case (id_ex.op)
      OP_ADD:  alu = fa + fb;
      OP_SUB:  alu = fa - fb;
      OP_AND:  alu = fa & fb;
      OP_OR:   alu = fa | fb;
      OP_SLT:  alu = 32'(fa < fb);
      OP_MUL:  alu = fa * fb;
      OP_SUBI: alu = fa - id_ex.imm;
      OP_SLTI: alu = 32'(fa < id_ex.imm);
      default: ;
    endcase
  end

  logic          taken, halt_now;
  logic [AW-1:0] target, m_addr;
  logic [31:0]   lmd;
  logic          sw_en;
  assign taken = (id_ex.t == T_BR)
               && ((id_ex.op == OP_BEQZ) ? (fa == 32'd0) : (fa != 32'd0));
  assign target = id_ex.npc + id_ex.imm[AW-1:0];
  assign halt_now = (d_t == T_HLT) && !taken;
  assign m_addr = ex_mem.alu[AW-1:0];
  assign lmd = mem[m_addr];
  assign sw_en = !rst && !halted && ex_mem.v && ex_mem.t == T_ST
               && !(prog_we && prog_addr == m_addr);

  always_ff @(posedge clk) begin
    if (sw_en) mem[m_addr] <= ex_mem.b;
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      stop <= 1'b0;
      halted <= 1'b0;
      if_id <= '0;
      id_ex <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      cycle_cnt <= '0;
      retired_cnt <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (mem_wb.v) retired_cnt <= retired_cnt + CNT_W'(1);
      if (mem_wb.v && mem_wb.t == T_HLT) halted <= 1'b1;
      if (wb_wr) rf[mem_wb.rd] <= mem_wb.res;
      mem_wb <= '{v: ex_mem.v, t: ex_mem.t, rd: ex_mem.rd,
                  we: ex_mem.we,
                  res: (ex_mem.t == T_LD) ? lmd : ex_mem.alu};
      ex_mem <= '{v: id_ex.v, t: id_ex.t, rd: id_ex.rd,
                  we: id_ex.we, alu: alu, b: fb};
      if (taken || stall) id_ex <= '0;
      else id_ex <= '{v: if_id.v, t: d_t, op: if_id.ir[31:26],
                      rs: d_rs, rt: d_rt, rd: d_dst, we: d_we,
                      a: d_a, b: d_b, imm: d_imm, npc: if_id.npc};
      if (stall && !taken) stall_cnt <= stall_cnt + CNT_W'(1);
      if (halt_now) stop <= 1'b1;
      if (taken) begin
        pc <= target;
        if_id <= '0;
      end else if (!stall) begin
        if (stop || halt_now) begin
          if_id <= '0;
        end else begin
          if_id <= '{v: 1'b1, ir: mem[pc], npc: pc + AW'(1)};
          pc <= pc + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_pipe_hazard.sv
// tb_mips_pipe_hazard: forwarding and interlock-only builds run the
// same programs; results are checked against an ISA-level model.
module tb_mips_pipe_hazard;
  localparam int AW = 10;
  localparam int DEPTH = 1024;
  localparam int CW = 32;

  localparam logic [5:0] ADD = 6'h00, SUB = 6'h01, AND_ = 6'h02;
  localparam logic [5:0] OR_ = 6'h03, SLT = 6'h04, MUL = 6'h05;
  localparam logic [5:0] LW = 6'h08, SW = 6'h09, ADDI = 6'h0a;
  localparam logic [5:0] SUBI = 6'h0b, SLTI = 6'h0c;
  localparam logic [5:0] BNEQZ = 6'h0d, BEQZ = 6'h0e, HLT = 6'h3f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [4:0]    dbg_raddr = '0;
  logic [31:0]   dr_f, dr_i;
  logic          h_f, h_i;
  logic [CW-1:0] cy_f, cy_i, rt_f, rt_i, st_f, st_i;

  int checks = 0;
  int failures = 0;

  logic [31:0] mmem [DEPTH];
  logic [31:0] mreg [32];
  int          mret;

  mips_pipe_hazard #(.MEM_DEPTH(DEPTH), .AW(AW), .FWD_EN(1),
                     .CNT_W(CW)) u_fwd (
    .clk(clk), .rst(rst), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dr_f), .halted(h_f),
    .cycle_cnt(cy_f), .retired_cnt(rt_f), .stall_cnt(st_f));

  mips_pipe_hazard #(.MEM_DEPTH(DEPTH), .AW(AW), .FWD_EN(0),
                     .CNT_W(CW)) u_int (
    .clk(clk), .rst(rst), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dr_i), .halted(h_i),
    .cycle_cnt(cy_i), .retired_cnt(rt_i), .stall_cnt(st_i));

  function automatic logic [31:0] ir_r(input logic [5:0] op,
      input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] ir_i(input logic [5:0] op,
      input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
      input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input int idx,
      input logic [31:0] exp);
    dbg_raddr = 5'(idx);
    #1;
    check({tag, "_fwd"}, dr_f, exp);
    check({tag, "_int"}, dr_i, exp);
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] w[$]);
    rst = 1'b1;
    foreach (w[i]) poke(i, w[i]);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!(h_f && h_i) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("halt_timeout", 32'(h_f && h_i), 32'd1);
  endtask

  task automatic run(input int budget);
    @(negedge clk);
    rst = 1'b0;
    wait_halt(budget);
  endtask

  // Sequential ISA interpreter: one instruction at a time, no pipeline
  task automatic model_run();
    int pc = 0;
    int steps = 0;
    bit done = 1'b0;
    logic [31:0] ir, a, b, imm, val;
    logic [5:0] op;
    int rs, rt, rd, dst;
    foreach (mreg[i]) mreg[i] = '0;
    mret = 0;
    while (!done && steps < 5000) begin
      ir = mmem[pc];
      op = ir[31:26];
      rs = int'(ir[25:21]);
      rt = int'(ir[20:16]);
      rd = int'(ir[15:11]);
      a = mreg[rs];
      b = mreg[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      dst = 0;
      val = '0;
      mret++;
      steps++;
      pc = (pc + 1) % DEPTH;
      case (op)
        ADD:  begin dst = rd; val = a + b; end
        SUB:  begin dst = rd; val = a - b; end
        AND_: begin dst = rd; val = a & b; end
        OR_:  begin dst = rd; val = a | b; end
        SLT:  begin dst = rd; val = (a < b) ? 32'd1 : 32'd0; end
        MUL:  begin dst = rd; val = a * b; end
        ADDI: begin dst = rt; val = a + imm; end
        SUBI: begin dst = rt; val = a - imm; end
        SLTI: begin dst = rt; val = (a < imm) ? 32'd1 : 32'd0; end
        LW: begin
          dst = rt;
          val = mmem[int'((a + imm) & 32'(DEPTH - 1))];
        end
        SW: mmem[int'((a + imm) & 32'(DEPTH - 1))] = b;
        BEQZ: if (a == 0)
          pc = int'((32'(pc) + imm) & 32'(DEPTH - 1));
        BNEQZ: if (a != 0)
          pc = int'((32'(pc) + imm) & 32'(DEPTH - 1));
        default: done = 1'b1;
      endcase
      if (dst != 0) mreg[dst] = val;
    end
  endtask

  initial begin
    logic [31:0] p[$];
    int k, rs, rt, rd, off;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_halted_fwd", 32'(h_f), 32'd0);
    check("rst_halted_int", 32'(h_i), 32'd0);
    check("rst_cycle", cy_f, 32'd0);
    check("rst_retired", rt_i, 32'd0);
    chk_reg("rst_r1", 1, 32'd0);

    p = '{ir_i(ADDI, 0, 1, 10), ir_i(ADDI, 0, 2, 20),
          ir_r(ADD, 1, 2, 3), ir_i(HLT, 0, 0, 0)};
    load_prog(p);
    run(500);
    chk_reg("b2b_r3", 3, 32'd30);
    check("b2b_stall_fwd", st_f, 32'd0);
    check("b2b_stall_int_nz", 32'(st_i != 0), 32'd1);
    check("b2b_ret_fwd", rt_f, 32'd4);
    check("b2b_ret_int", rt_i, 32'd4);

    rst = 1'b1;
    poke(120, 32'd85);
    p = '{ir_i(ADDI, 0, 1, 120), ir_i(LW, 1, 2, 0),
          ir_i(ADDI, 2, 3, 45), ir_i(HLT, 0, 0, 0)};
    load_prog(p);
    run(500);
    chk_reg("lu_r3", 3, 32'd130);
    check("lu_stall_fwd", st_f, 32'd1);

    p = '{ir_i(BEQZ, 0, 0, 2), ir_i(ADDI, 0, 5, 1),
          ir_i(ADDI, 0, 5, 2), ir_i(BNEQZ, 0, 0, 1),
          ir_i(ADDI, 0, 6, 3), ir_i(HLT, 0, 0, 0)};
    load_prog(p);
    run(500);
    chk_reg("br_r5", 5, 32'd0);
    chk_reg("br_r6", 6, 32'd3);
    check("br_ret_fwd", rt_f, 32'd4);
    check("br_ret_int", rt_i, 32'd4);

    p = '{ir_i(ADDI, 0, 10, 7), ir_i(ADDI, 0, 2, 1),
          ir_r(MUL, 2, 10, 2), ir_i(SUBI, 10, 10, 1),
          ir_i(BNEQZ, 10, 0, -3), ir_i(SW, 0, 2, 198),
          ir_i(LW, 0, 20, 198), ir_i(HLT, 0, 0, 0)};
    load_prog(p);
    run(3000);
    chk_reg("fact_r2", 2, 32'd5040);
    chk_reg("fact_mem198", 20, 32'd5040);
    check("fact_ret_fwd", rt_f, 32'd26);
    check("fact_ret_int", rt_i, 32'd26);

    p = '{ir_i(ADDI, 0, 8, 5), ir_i(HLT, 0, 0, 0),
          ir_i(ADDI, 0, 7, 1)};
    load_prog(p);
    run(500);
    repeat (5) @(negedge clk);
    chk_reg("hlt_r7", 7, 32'd0);
    chk_reg("hlt_r8", 8, 32'd5);
    check("hlt_cycle_fwd", cy_f, 32'd6);
    check("hlt_cycle_int", cy_i, 32'd6);
    check("hlt_ret", rt_f, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rerst_halted", 32'(h_f || h_i), 32'd0);
    check("rerst_cycle", cy_f, 32'd0);
    chk_reg("rerst_r8", 8, 32'd0);
    run(500);
    chk_reg("rerun_r8", 8, 32'd5);
    chk_reg("rerun_r7", 7, 32'd0);

    rst = 1'b1;
    poke(300, 32'h1111);
    p = '{ir_i(SW, 0, 0, 300), ir_i(ADDI, 0, 0, 5),
          ir_i(ADDI, 0, 1, 1), ir_i(LW, 0, 9, 300),
          ir_i(HLT, 0, 0, 0)};
    load_prog(p);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = AW'(300);
    prog_data = 32'hCAFE;
    @(negedge clk);
    prog_we = 1'b0;
    wait_halt(500);
    chk_reg("prio_r9", 9, 32'hCAFE);
    chk_reg("r0_zero", 0, 32'd0);
    chk_reg("prio_r1", 1, 32'd1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 24; i++) begin
        k = $urandom_range(0, 9);
        rs = $urandom_range(0, 5);
        rt = $urandom_range(0, 5);
        rd = $urandom_range(0, 5);
        case (k)
          0, 1, 2: mmem[i] = ir_r(6'($urandom_range(0, 5)), rs, rt, rd);
          3, 4: mmem[i] = ir_i(6'(ADDI + 6'($urandom_range(0, 2))),
                               rs, rt, $urandom_range(0, 65535));
          5: mmem[i] = ir_i(LW, 0, rt, 512 + $urandom_range(0, 15));
          6: mmem[i] = ir_i(SW, 0, rt, 512 + $urandom_range(0, 15));
          7: begin
            off = $urandom_range(0, 3);
            if (i + 1 + off > 24) off = 23 - i;
            mmem[i] = ir_i(($urandom_range(0, 1) != 0) ? BEQZ : BNEQZ,
                           rs, 0, off);
          end
          default: mmem[i] = ir_i(ADDI, rs, rt, $urandom_range(0, 9));
        endcase
      end
      mmem[24] = ir_i(HLT, 0, 0, 0);
      mmem[25] = ir_i(ADDI, 0, 7, 1);
      for (int i = 512; i < 528; i++) mmem[i] = $urandom;
      rst = 1'b1;
      for (int i = 0; i < 26; i++) poke(i, mmem[i]);
      for (int i = 512; i < 528; i++) poke(i, mmem[i]);
      model_run();
      run(3000);
      for (int r = 1; r < 6; r++)
        chk_reg($sformatf("rnd%0d_r%0d", t, r), r, mreg[r]);
      chk_reg($sformatf("rnd%0d_r7", t), 7, 32'd0);
      check($sformatf("rnd%0d_ret_fwd", t), rt_f, 32'(mret));
      check($sformatf("rnd%0d_ret_int", t), rt_i, 32'(mret));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
